// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Function : RV32 load/store sequencer onto a word-wide valid/ready data port,
//            with read-modify-write for sub-word stores to cacheable memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter logic [23:0] MMIO_HI = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_w_valid,
    output logic        mem_r_valid,
    input  logic        mem_w_ready,
    input  logic        mem_r_ready,
    input  logic [31:0] mem_r_data
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        WRITE     = 3'd2,
        RMW_READ  = 3'd3,
        RMW_WRITE = 3'd4,
        RESP      = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_word;
    logic [31:0] r_rdata;

    logic        w_req_byte;
    logic        w_req_half;
    logic        w_req_misalign;
    logic        w_req_mmio;
    logic [31:0] w_req_word;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    // Loads decode size from funct3[1:0]; stores only honour 000/001 as sub-word.
    assign w_req_byte     = (req_funct3[1:0] == 2'b00) && !(req_we && req_funct3[2]);
    assign w_req_half     = (req_funct3[1:0] == 2'b01) && !(req_we && req_funct3[2]);
    assign w_req_misalign = (w_req_half && req_addr[0]) ||
                            (!w_req_byte && !w_req_half && (req_addr[1:0] != 2'b00));
    assign w_req_mmio     = (req_addr[31:8] == MMIO_HI);

    // Sub-word MMIO stores go out unshifted and zero-extended; cacheable ones keep raw data for the merge.
    always_comb begin
        w_req_word = req_wdata;
        if (req_we && w_req_mmio && w_req_byte) begin
            w_req_word = {24'b0, req_wdata[7:0]};
        end else if (req_we && w_req_mmio && w_req_half) begin
            w_req_word = {16'b0, req_wdata[15:0]};
        end
    end

    assign w_lane_b = mem_r_data[{r_addr[1:0], 3'b000} +: 8];
    assign w_lane_h = r_addr[1] ? mem_r_data[31:16] : mem_r_data[15:0];

    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{24{w_lane_b[7]}}, w_lane_b};
            3'b100:  w_load = {24'b0, w_lane_b};
            3'b001:  w_load = {{16{w_lane_h[15]}}, w_lane_h};
            3'b101:  w_load = {16'b0, w_lane_h};
            default: w_load = mem_r_data;
        endcase
    end

    always_comb begin
        w_merged = mem_r_data;
        if (r_funct3[0]) begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_word[15:0];
        end else begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_word[7:0];
        end
    end

    always_comb begin
        w_next      = r_state;
        stall       = 1'b0;
        done        = 1'b0;
        misalign    = 1'b0;
        mem_r_valid = 1'b0;
        mem_w_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_misalign) begin
                        misalign = 1'b1;
                    end else begin
                        stall = 1'b1;
                        if (!req_we) begin
                            w_next = READ;
                        end else if ((w_req_byte || w_req_half) && !w_req_mmio) begin
                            w_next = RMW_READ;
                        end else begin
                            w_next = WRITE;
                        end
                    end
                end
            end
            READ, RMW_READ: begin
                stall       = 1'b1;
                mem_r_valid = 1'b1;
                if (mem_r_ready) begin
                    w_next = (r_state == READ) ? RESP : RMW_WRITE;
                end
            end
            WRITE, RMW_WRITE: begin
                stall       = 1'b1;
                mem_w_valid = 1'b1;
                if (mem_w_ready) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= 32'b0;
            r_funct3 <= 3'b0;
            r_word   <= 32'b0;
            r_rdata  <= 32'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid) begin
                r_addr   <= req_addr;
                r_funct3 <= req_funct3;
                r_word   <= w_req_word;
            end
            if (r_state == READ && mem_r_ready) begin
                r_rdata <= w_load;
            end
            if (r_state == RMW_READ && mem_r_ready) begin
                r_word <= w_merged;
            end
        end
    end

    assign rdata     = r_rdata;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_word;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Function : Directed self-checking bench for mem_access_unit with a
//            behavioural memory-port responder and transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        stall, done, misalign, mem_w_valid, mem_r_valid;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        mem_w_ready = 1'b0;
    logic        mem_r_ready = 1'b0;
    logic [31:0] mem_r_data = 32'b0;

    int checks = 0;
    int errors = 0;

    int          r_wait = 0, w_wait = 0, rcnt = 0, wcnt = 0;
    logic [31:0] mem_word = 32'b0;
    logic [31:0] exp_addr = 32'b0, exp_wword = 32'b0, exp_rdata = 32'b0, last_wword = 32'b0;
    int          n_rd = 0, n_wr = 0, n_done = 0;

    mem_access_unit #(.MMIO_HI(24'h000000)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .rdata(rdata), .misalign(misalign),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_w_valid(mem_w_valid), .mem_r_valid(mem_r_valid),
        .mem_w_ready(mem_w_ready), .mem_r_ready(mem_r_ready),
        .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Behavioural model of the access rules
    function automatic int size_of(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        int          sz;
        logic [31:0] v;
        sz = size_of(1'b0, f3);
        if (sz == 4) return w;
        if (sz == 1) v = (w >> (8 * off)) & 32'hFF;
        else         v = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'd0 && v >= 128)   v = v - 256;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        return v;
    endfunction

    function automatic logic [31:0] merge_val(input int sz, input logic [1:0] off,
                                              input logic [31:0] w, input logic [31:0] d);
        logic [31:0] mask;
        mask = (sz == 1) ? (32'hFF << (8 * off)) : (32'hFFFF << (8 * off));
        return (w & ~mask) | ((d << (8 * off)) & mask);
    endfunction

    // Memory-port responder: ready after a programmed number of wait cycles
    always @(posedge clk) begin
        #1;
        if (mem_r_valid) begin
            mem_r_ready = (rcnt == r_wait);
            mem_r_data  = mem_word;
            rcnt++;
        end else begin
            mem_r_ready = 1'b0;
            mem_r_data  = 32'h0BAD0BAD;
            rcnt        = 0;
        end
        if (mem_w_valid) begin
            mem_w_ready = (wcnt == w_wait);
            wcnt++;
        end else begin
            mem_w_ready = 1'b0;
            wcnt        = 0;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_r_valid || mem_w_valid) begin
                check("one_valid", {31'b0, mem_r_valid & mem_w_valid}, 32'd0);
                check("mem_addr", mem_addr, exp_addr);
            end
            if (mem_w_valid) check("mem_wdata", mem_wdata, exp_wword);
            if (mem_r_valid && mem_r_ready) n_rd++;
            if (mem_w_valid && mem_w_ready) begin
                n_wr++;
                last_wword = mem_wdata;
            end
            if (done) begin
                n_done++;
                check("rdata_at_done", rdata, exp_rdata);
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rword,
                          input int rw, input int ww, input logic [31:0] lit);
        int sz, lat, erd, ewr, cyc;
        sz       = size_of(we, f3);
        mem_word = rword;
        r_wait   = rw;
        w_wait   = ww;
        exp_addr = {addr[31:2], 2'b00};
        if (!we) begin
            exp_rdata = load_val(f3, addr[1:0], rword);
            erd = 1; ewr = 0; lat = 2 + rw;
        end else if (sz == 4) begin
            exp_wword = wdata;
            erd = 0; ewr = 1; lat = 2 + ww;
        end else if (addr[31:8] == 24'h000000) begin
            exp_wword = wdata & ((sz == 1) ? 32'hFF : 32'hFFFF);
            erd = 0; ewr = 1; lat = 2 + ww;
        end else begin
            exp_wword = merge_val(sz, addr[1:0], rword, wdata);
            erd = 1; ewr = 1; lat = 3 + rw + ww;
        end
        n_rd = 0; n_wr = 0; n_done = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1;
        check("stall_req", {31'b0, stall}, 32'd1);
        check("misalign_req", {31'b0, misalign}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        cyc = 1;
        while (!done && cyc < 60) begin
            check("stall_busy", {31'b0, stall}, 32'd1);
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, lat);
        check("stall_done", {31'b0, stall}, 32'd0);
        @(negedge clk);
        #1;
        check("done_pulse", {31'b0, done}, 32'd0);
        check("n_done", n_done, 1);
        check("n_rd", n_rd, erd);
        check("n_wr", n_wr, ewr);
        if (we) check("wword_lit", last_wword, lit);
        else    check("rdata_lit", rdata, lit);
    endtask

    task automatic mis_req(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        n_rd = 0; n_wr = 0; n_done = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
        #1;
        check("misalign_flag", {31'b0, misalign}, 32'd1);
        check("misalign_stall", {31'b0, stall}, 32'd0);
        check("misalign_valid", {30'b0, mem_r_valid, mem_w_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("misalign_after", {29'b0, mem_r_valid, mem_w_valid, done}, 32'd0);
        check("misalign_rdata", rdata, exp_rdata);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ctrl", {27'b0, stall, done, misalign, mem_w_valid, mem_r_valid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        rst = 1'b0;

        do_req(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);
        do_req(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 32'h0000_0080);
        do_req(1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h80FF_1234, 0, 0, 32'hFFFF_80FF);
        do_req(1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'h80FF_1234, 1, 0, 32'h0000_80FF);
        do_req(1'b1, 3'b000, 32'h0000_2001, 32'h0000_00AB, 32'h1122_3344, 3, 0, 32'h1122_AB44);
        do_req(1'b1, 3'b001, 32'h0000_00F4, 32'hCAFE_5678, 32'h0, 0, 0, 32'h0000_5678);
        do_req(1'b1, 3'b010, 32'h0000_3004, 32'h0BAD_F00D, 32'h0, 0, 2, 32'h0BAD_F00D);
        do_req(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h1122_3344, 0, 1, 32'hBEEF_3344);

        mis_req(1'b0, 3'b010, 32'h0000_1002);
        mis_req(1'b1, 3'b001, 32'h0000_2001);

        // Reset while a cacheable sub-word store waits on its read
        r_wait = 1000;
        exp_addr = 32'h0000_2000;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0000_2001;
        req_wdata = 32'h0000_00AB;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rmw_pending", {31'b0, mem_r_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ctrl", {28'b0, stall, done, mem_w_valid, mem_r_valid}, 32'd0);
        check("abort_addr", mem_addr, 32'd0);
        rst = 1'b0;
        exp_rdata = 32'd0;
        n_done = 0;
        repeat (3) @(negedge clk);
        #1;
        check("abort_no_done", n_done, 0);

        do_req(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'h1234_5678, 0, 0, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential load/store controller between the CPU MEM pipeline stage and the cache/MMIO data port. It converts RV32 byte, halfword and word loads/stores into word-aligned, valid/ready transactions on that port. It performs read-modify-write for sub-word stores to cacheable memory, sign/zero-extends load results, and stalls the pipeline until the access completes.

## Interface
Parameters:
- MMIO_HI, 24'h000000, value of addr[31:8] that marks an MMIO address.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM stage holds a memory instruction
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- stall  out  1  freeze the pipeline
- done  out  1  one-cycle pulse when the access completes
- rdata  out  32  extended load result; held until the next load completes
- misalign  out  1  misaligned request; no access issued
- mem_addr  out  32  word-aligned address (bits [1:0] = 0)
- mem_wdata  out  32  write word
- mem_w_valid / mem_r_valid  out  1  write / read request
- mem_w_ready / mem_r_ready  in  1  completion strobes
- mem_r_data  in  32  read word; valid when mem_r_ready = 1

## Operation
States: IDLE, READ, WRITE, RMW_READ, RMW_WRITE, RESP.
- IDLE, req_valid = 1:
  - Latch addr, funct3, we and wdata.
  - If misaligned (h with addr[0] = 1; w with addr[1:0] ≠ 0): misalign = 1 combinationally, stall = 0, stay in IDLE, issue nothing.
  - Load → READ.
  - sw → WRITE.
  - sb/sh to a cacheable address → RMW_READ.
  - sb/sh to MMIO (addr[31:8] == MMIO_HI) → WRITE. The word written is the zero-extended byte/half, unshifted. No read is issued, so reads with side effects are never triggered.
- READ: mem_r_valid = 1. On mem_r_ready, extract the lane selected by addr[1:0] (b) or addr[1] (h), extend it, register it into rdata, then → RESP.
- RMW_READ: mem_r_valid = 1. On mem_r_ready, merge the store lane of wdata into mem_r_data, register the merged word, then → RMW_WRITE.
- WRITE / RMW_WRITE: mem_w_valid = 1 with the latched or merged word. On mem_w_ready → RESP.
- RESP: done = 1, stall = 0, → IDLE.
- Extension rules:
  - funct3 000 and 001 sign-extend.
  - 100 and 101 zero-extend.
  - 010 passes the word through.
  - Store funct3 uses only 000, 001 and 010. Any other funct3 is treated as 010 (word).
- stall = 1 in IDLE when req_valid = 1 and the request is aligned. stall = 1 throughout READ, WRITE, RMW_READ and RMW_WRITE. Otherwise stall = 0.
- mem_addr = {latched addr[31:2], 2'b00}. Outside active states, mem_w_valid = mem_r_valid = 0.
- req_* inputs are sampled only in IDLE. Changes in any other state are ignored.
- Never assert mem_r_valid and mem_w_valid together.

## Timing
- Reset: state = IDLE. done, misalign, stall, mem_w_valid and mem_r_valid are 0. rdata, mem_wdata and mem_addr are 0.
- Reset asserted mid-transaction: abandon the access at that edge. Valids drop in the next cycle. Do not complete the access and do not pulse done.
- A ready strobe counts only in a cycle where the matching valid is high. This includes the first cycle of the state (zero-wait port). Ready strobes in other states are ignored.
- Downstream rule: mem_addr, mem_wdata and the valid signal stay stable until ready.
- Minimum latency with zero-wait ready, counted from the request cycle T:
  - Load and sw: done at T+2; stall high in T and T+1.
  - Cacheable sb/sh: done at T+3.
  - Each wait cycle on ready adds one cycle.
- A new req_valid in the RESP cycle belongs to the next instruction and is accepted in the following IDLE cycle. There is no back-to-back overlap.

## Test plan
- lw at 0x1000, mem_r_data = 0xDEADBEEF, ready on first cycle → done at T+2, rdata = 0xDEADBEEF, stall high exactly 2 cycles.
- lb at 0x1003 and lbu at 0x1003, mem_r_data = 0x80FF1234 → rdata = 0xFFFFFF80 and 0x00000080 respectively. Then lh at 0x1002 → rdata = 0xFFFF80FF.
- sb 0xAB to 0x2001, read returns 0x11223344, 3 wait cycles before r_ready → one read then one write with mem_wdata = 0x1122AB44, mem_addr = 0x2000, done once.
- sh 0x5678 to MMIO address 0x000000F4 → no read issued, single write with mem_wdata = 0x00005678, done at T+2.
- lw at 0x1002 → misalign = 1 in T, stall = 0, no mem valid, rdata unchanged.
- Reset asserted during RMW_READ with ready withheld → next cycle state IDLE, all valids 0, no done pulse. A following lw completes normally.
